// File: rtl/scrolling_display_n.sv
// scrolling_display_n: N-digit multiplexed common-anode 7-segment scroller.
// ASCII characters are appended one per falling edge of dsn into a small
// buffer. Text longer than the display rotates circularly across the digits.
// Optional build macro SCROLL_PAUSE_EN adds an active-low pausen input that
// freezes the scroll offset while it is held low.
module scrolling_display_n #(
  parameter int NUM_DIGITS       = 4,
  parameter int BUF_DEPTH        = 16,
  parameter int SCROLL_CLK_BITS  = 24,
  parameter int DISPLAY_CLK_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            ascii,
  input  logic                  dsn,
  input  logic                  clearn,
`ifdef SCROLL_PAUSE_EN
  input  logic                  pausen,
`endif
  output logic [7:0]            segments,
  output logic [NUM_DIGITS-1:0] digit_select,
  output logic [7:0]            leds
);

  // Count must reach BUF_DEPTH (<= 31), so five bits always suffice.
  localparam int CNT_W  = 5;
  localparam int SUM_W  = CNT_W + 1;
  localparam int ADDR_W = $clog2(BUF_DEPTH);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0]      DIGITS_C = CNT_W'(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DSEL_RST = ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1));

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_OTHER = 8'hB6;

  // Write strobe detection
  logic                        dsn_q_reg;
  logic                        write_stb;

  // Buffer bookkeeping
  logic [CNT_W-1:0]            count_reg;
  logic [CNT_W-1:0]            count_next;
  logic [CNT_W-1:0]            offset_reg;
  logic [CNT_W-1:0]            offset_next;
  logic                        overflow_reg;
  logic                        overflow_next;
  logic                        buf_we;
  logic [7:0]                  buf_mem [BUF_DEPTH];

  // Prescalers
  logic [SCROLL_CLK_BITS-1:0]  scroll_pre_reg;
  logic [DISPLAY_CLK_BITS-1:0] disp_pre_reg;
  logic                        scroll_tick;
  logic                        disp_tick;
  logic                        scroll_hold;

  // Digit multiplexing and output registers
  logic [IDX_W-1:0]            mux_idx_reg;
  logic [IDX_W-1:0]            mux_idx_next;
  logic [SUM_W-1:0]            rd_sum;
  logic [ADDR_W-1:0]           rd_addr;
  logic [7:0]                  seg_reg;
  logic [7:0]                  seg_next;
  logic [NUM_DIGITS-1:0]       dsel_reg;
  logic [NUM_DIGITS-1:0]       dsel_next;

  // ASCII to active-low {dp,g,f,e,d,c,b,a}; letters are case-folded first.
  function automatic logic [7:0] ascii_to_seg(input logic [7:0] code);
    logic [7:0] c;
    logic [7:0] seg;
    seg = SEG_OTHER;
    c   = (code >= 8'h61 && code <= 8'h7A) ? (code - 8'h20) : code;
    case (c)
      8'h20: seg = SEG_BLANK; // space
      8'h2D: seg = SEG_DASH;  // '-'
      8'h30: seg = 8'hC0;
      8'h31: seg = 8'hF9;
      8'h32: seg = 8'hA4;
      8'h33: seg = 8'hB0;
      8'h34: seg = 8'h99;
      8'h35: seg = 8'h92;
      8'h36: seg = 8'h82;
      8'h37: seg = 8'hF8;
      8'h38: seg = 8'h80;
      8'h39: seg = 8'h90;
      8'h41: seg = 8'h88; // A
      8'h42: seg = 8'h83; // b
      8'h43: seg = 8'hC6; // C
      8'h44: seg = 8'hA1; // d
      8'h45: seg = 8'h86; // E
      8'h46: seg = 8'h8E; // F
      8'h47: seg = 8'hC2; // G
      8'h48: seg = 8'h89; // H
      8'h49: seg = 8'hCF; // I (left bars, distinct from '1')
      8'h4A: seg = 8'hE1; // J
      8'h4B: seg = 8'h8A; // K (approximation)
      8'h4C: seg = 8'hC7; // L
      8'h4D: seg = 8'hC8; // M (approximation)
      8'h4E: seg = 8'hAB; // n
      8'h4F: seg = 8'hA3; // o
      8'h50: seg = 8'h8C; // P
      8'h51: seg = 8'h98; // q
      8'h52: seg = 8'hAF; // r
      8'h53: seg = 8'h92; // S
      8'h54: seg = 8'h87; // t
      8'h55: seg = 8'hC1; // U
      8'h56: seg = 8'hE3; // v
      8'h57: seg = 8'h81; // W (approximation)
      8'h58: seg = 8'h89; // X (same as H)
      8'h59: seg = 8'h91; // y
      8'h5A: seg = 8'hA4; // Z
      default: seg = SEG_OTHER;
    endcase
    return seg;
  endfunction

  assign write_stb   = dsn_q_reg & ~dsn;
  assign scroll_tick = &scroll_pre_reg;
  assign disp_tick   = &disp_pre_reg;

`ifdef SCROLL_PAUSE_EN
  assign scroll_hold = ~pausen;
`else
  assign scroll_hold = 1'b0;
`endif

  // Register dsn so only its falling edge produces a write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dsn_q_reg <= 1'b1;
    end else begin
      dsn_q_reg <= dsn;
    end
  end

  // Next-state for count, overflow and scroll offset; clear wins over a write.
  always_comb begin
    count_next    = count_reg;
    offset_next   = offset_reg;
    overflow_next = overflow_reg;
    buf_we        = 1'b0;
    if (!clearn) begin
      count_next    = '0;
      offset_next   = '0;
      overflow_next = 1'b0;
    end else begin
      if (write_stb) begin
        if (count_reg < DEPTH_C) begin
          buf_we     = 1'b1;
          count_next = count_reg + CNT_W'(1);
        end else begin
          overflow_next = 1'b1;
        end
      end
      // Wrap test uses the current count, so a concurrent write only
      // lengthens the rotation and never moves the offset.
      if (count_reg <= DIGITS_C) begin
        offset_next = '0;
      end else if (scroll_tick && !scroll_hold) begin
        offset_next = (offset_reg == count_reg - CNT_W'(1)) ? '0
                                                            : offset_reg + CNT_W'(1);
      end
    end
  end

  // Buffer bookkeeping and free-running prescalers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg      <= '0;
      offset_reg     <= '0;
      overflow_reg   <= 1'b0;
      scroll_pre_reg <= '0;
      disp_pre_reg   <= '0;
    end else begin
      count_reg      <= count_next;
      offset_reg     <= offset_next;
      overflow_reg   <= overflow_next;
      scroll_pre_reg <= scroll_pre_reg + SCROLL_CLK_BITS'(1);
      disp_pre_reg   <= disp_pre_reg + DISPLAY_CLK_BITS'(1);
    end
  end

  // Character storage; contents beyond count are never displayed, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[ADDR_W'(count_reg)] <= ascii;
    end
  end

  // Digit index advances on every display prescaler wrap.
  always_comb begin
    mux_idx_next = mux_idx_reg;
    if (disp_tick) begin
      mux_idx_next = (mux_idx_reg == LAST_IDX) ? '0 : mux_idx_reg + IDX_W'(1);
    end
  end

  // Pick the glyph for the digit that will be active next cycle, so
  // segments and digit_select change on the same edge. When count is at
  // most NUM_DIGITS the offset is zero, so the address reduces to k.
  always_comb begin
    rd_sum = SUM_W'(offset_reg) + SUM_W'(mux_idx_next);
    if (rd_sum >= SUM_W'(count_reg)) begin
      rd_sum = rd_sum - SUM_W'(count_reg);
    end
    rd_addr  = ADDR_W'(rd_sum);
    seg_next = SEG_DASH;
    if (count_reg == '0) begin
      seg_next = SEG_DASH;
    end else if (count_reg <= DIGITS_C && CNT_W'(mux_idx_next) >= count_reg) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = ascii_to_seg(buf_mem[rd_addr]);
    end
  end

  // Active-low one-hot enable; digit 0 is the leftmost (top bit).
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dsel
      assign dsel_next[gi] = (mux_idx_next != IDX_W'(NUM_DIGITS - 1 - gi));
    end
  endgenerate

  // Mux index and registered display outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mux_idx_reg <= '0;
      seg_reg     <= SEG_DASH;
      dsel_reg    <= DSEL_RST;
    end else begin
      mux_idx_reg <= mux_idx_next;
      seg_reg     <= seg_next;
      dsel_reg    <= dsel_next;
    end
  end

  assign segments     = seg_reg;
  assign digit_select = dsel_reg;
  assign leds         = {overflow_reg, (count_reg == DEPTH_C), (count_reg == '0), count_reg};

endmodule
